// File: rtl/byte_block_packer.sv
// Packs an MSB-first byte stream into 64-bit blocks behind a held output register.
// Define PACKER_PARITY_EN to flag blocks containing bytes that fail odd parity.
module byte_block_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [63:0] block_out,
  output logic        block_valid,
  input  logic        block_ready,
  output logic        block_perr,
  output logic [3:0]  fill_level
);

  logic [2:0]  cnt_q, cnt_d;
  logic [55:0] acc_q, acc_d;
  logic [63:0] blk_q, blk_d;
  logic        blk_vld_q, blk_vld_d;
  logic        accept;
  logic        last_byte;

  // The final byte may only load once the output register has been emptied.
  assign byte_ready = !((cnt_q == 3'd7) && blk_vld_q);
  assign accept     = byte_valid && byte_ready && !clear;
  assign last_byte  = (cnt_q == 3'd7);

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    blk_d     = blk_q;
    blk_vld_d = blk_vld_q;
    if (blk_vld_q && block_ready)
      blk_vld_d = 1'b0;
    if (clear) begin
      cnt_d = 3'd0;
    end else if (accept) begin
      if (last_byte) begin
        blk_d     = {acc_q, byte_in};
        blk_vld_d = 1'b1;
        cnt_d     = 3'd0;
      end else begin
        for (int i = 0; i < 7; i++)
          if (cnt_q == 3'(i))
            acc_d[55-8*i -: 8] = byte_in;
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 3'd0;
      acc_q     <= 56'd0;
      blk_q     <= 64'd0;
      blk_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      blk_q     <= blk_d;
      blk_vld_q <= blk_vld_d;
    end
  end

`ifdef PACKER_PARITY_EN
  logic err_q, err_d;
  logic perr_q, perr_d;
  logic byte_err;

  assign byte_err = ~^byte_in;

  // Error flag is sticky across the partial block and moves out with it.
  always_comb begin
    err_d  = err_q;
    perr_d = perr_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (accept) begin
      if (last_byte) begin
        perr_d = err_q | byte_err;
        err_d  = 1'b0;
      end else begin
        err_d = err_q | byte_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      perr_q <= perr_d;
    end
  end

  assign block_perr = perr_q;
`else
  assign block_perr = 1'b0;
`endif

  assign block_out   = blk_q;
  assign block_valid = blk_vld_q;
  assign fill_level  = {1'b0, cnt_q};

endmodule

// File: tb/tb_byte_block_packer.sv
// Directed bench for byte_block_packer with a queued scoreboard and an independent output monitor.
module tb_byte_block_packer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [63:0] block_out;
  logic        block_valid;
  logic        block_ready;
  logic        block_perr;
  logic [3:0]  fill_level;

`ifdef PACKER_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  typedef struct {
    logic [63:0] blk;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   vld_cnt;
  int   rdy_low_cnt;

  byte_block_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_perr  (block_perr),
    .fill_level  (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [63:0] blk, input logic perr);
    exp_t e;
    e.blk  = blk;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 50) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk);
    logic [63:0] tmp;
    tmp = blk;
    for (int i = 0; i < 8; i++) begin
      send_byte(tmp[63:56]);
      tmp = tmp << 8;
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  initial begin
    exp_t        e;
    logic        held;
    logic [63:0] held_blk;
    logic        held_perr;
    held = 1'b0;
    held_blk = 64'd0;
    held_perr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (block_valid) vld_cnt++;
        if (!byte_ready) rdy_low_cnt++;
        if (held && block_valid) begin
          chk("hold_block_out", block_out, held_blk);
          chk("hold_block_perr", {63'd0, block_perr}, {63'd0, held_perr});
        end
        held      = block_valid && !block_ready;
        held_blk  = block_out;
        held_perr = block_perr;
        if (block_valid && block_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_block", block_out, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("block_out", block_out, e.blk);
            chk("block_perr", {63'd0, block_perr}, {63'd0, e.perr});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int r0;
    n_checks = 0;
    n_fail = 0;
    vld_cnt = 0;
    rdy_low_cnt = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    block_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_block_valid", {63'd0, block_valid}, 64'd0);
    chk("rst_block_out", block_out, 64'd0);
    chk("rst_block_perr", {63'd0, block_perr}, 64'd0);
    chk("rst_byte_ready", {63'd0, byte_ready}, 64'd1);
    chk("rst_fill_level", {60'd0, fill_level}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous streaming with the sink always ready.
    block_ready = 1'b1;
    v0 = vld_cnt;
    r0 = rdy_low_cnt;
    push_exp(64'h0102030405060708, 1'b0);
    send_block(64'h0102030405060708);
    @(negedge clk);
    chk("latency_valid", {63'd0, block_valid}, 64'd1);
    chk("latency_block", block_out, 64'h0102030405060708);
    repeat (3) @(posedge clk);
    #1;
    chk("valid_one_cycle", 64'(vld_cnt - v0), 64'd1);
    chk("ready_never_low", 64'(rdy_low_cnt - r0), 64'd0);

    // Backpressure: first block held, next block stalls at seven bytes.
    block_ready = 1'b0;
    push_exp(64'h1011121314151617, 1'b0);
    push_exp(64'h18191A1B1C1D1E1F, 1'b0);
    for (int i = 8'h10; i <= 8'h1E; i++) send_byte(8'(i));
    @(negedge clk);
    chk("bp_byte_ready", {63'd0, byte_ready}, 64'd0);
    chk("bp_fill_level", {60'd0, fill_level}, 64'd7);
    chk("bp_block_valid", {63'd0, block_valid}, 64'd1);
    chk("bp_block_out", block_out, 64'h1011121314151617);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_block_stable", block_out, 64'h1011121314151617);
    @(posedge clk); #1;
    block_ready = 1'b1;
    byte_in = 8'h1F;
    byte_valid = 1'b1;
    @(negedge clk);
    chk("bubble_ready_low", {63'd0, byte_ready}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble_ready_high", {63'd0, byte_ready}, 64'd1);
    chk("bubble_valid_low", {63'd0, block_valid}, 64'd0);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    @(negedge clk);
    chk("second_valid", {63'd0, block_valid}, 64'd1);
    chk("second_block", block_out, 64'h18191A1B1C1D1E1F);
    @(posedge clk); #1;

    // Clear drops the partial block and the byte offered alongside it.
    send_byte(8'h30);
    send_byte(8'h31);
    send_byte(8'h32);
    @(negedge clk);
    chk("pre_clear_fill", {60'd0, fill_level}, 64'd3);
    @(posedge clk); #1;
    clear = 1'b1;
    byte_in = 8'h33;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    chk("post_clear_fill", {60'd0, fill_level}, 64'd0);
    @(posedge clk); #1;
    push_exp(64'hA1A2A3A4A5A6A7A8, 1'b0);
    send_block(64'hA1A2A3A4A5A6A7A8);
    repeat (2) @(posedge clk);
    #1;

    // Parity: good key, one even-parity byte, good key again.
    push_exp(64'h0102040810204080, 1'b0);
    send_block(64'h0102040810204080);
    push_exp(64'h0102040811204080, PAR);
    send_block(64'h0102040811204080);
    push_exp(64'h0102040810204080, 1'b0);
    send_block(64'h0102040810204080);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-block with a held output discards everything.
    block_ready = 1'b0;
    send_block(64'hB0B1B2B3B4B5B6B7);
    for (int i = 8'hD0; i <= 8'hD4; i++) send_byte(8'(i));
    @(negedge clk);
    chk("prerst_valid", {63'd0, block_valid}, 64'd1);
    chk("prerst_fill", {60'd0, fill_level}, 64'd5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_block_valid", {63'd0, block_valid}, 64'd0);
    chk("midrst_block_out", block_out, 64'd0);
    chk("midrst_block_perr", {63'd0, block_perr}, 64'd0);
    chk("midrst_byte_ready", {63'd0, byte_ready}, 64'd1);
    chk("midrst_fill_level", {60'd0, fill_level}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    block_ready = 1'b1;
    push_exp(64'hC1C2C3C4C5C6C7C8, 1'b0);
    send_block(64'hC1C2C3C4C5C6C7C8);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
